// File: rtl/ir_cmd_sequencer_if.sv
// ir_cmd_sequencer_if: frame input, decoder handshake and command output bundle
// for ir_cmd_sequencer. The master modport is the sequencer's view; the slave
// modport is the view of the surrounding logic (receiver, decoder, game side).
interface ir_cmd_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          frame_valid;
    logic [31:0]                   frame_data;
    logic [31:0]                   dec_raw;
    logic                          dec_latch;
    logic [31:0]                   dec_code;
    logic                          cmd_valid;
    logic [3:0]                    cmd_code;
    logic                          cmd_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          drop_unknown;
    logic                          overflow;
    logic                          busy;

    modport master (
        input  frame_valid, frame_data, dec_code, cmd_ready,
        output dec_raw, dec_latch, cmd_valid, cmd_code, fifo_count,
               drop_unknown, overflow, busy
    );

    modport slave (
        output frame_valid, frame_data, dec_code, cmd_ready,
        input  dec_raw, dec_latch, cmd_valid, cmd_code, fifo_count,
               drop_unknown, overflow, busy
    );
endinterface

// File: rtl/ir_cmd_sequencer.sv
// ir_cmd_sequencer: drives an external IR code decoder with raw frames, captures
// the decoded command, filters unknown codes and held-button repeats, and queues
// accepted commands in a first-word-fall-through FIFO.
// Optional macro IR_AUTO_REPEAT_EN: directional codes 5..8 held within the
// holdoff window are re-issued at most once per HOLDOFF_CYCLES/4 cycles.
module ir_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int LATCH_WIDTH    = 2,
    parameter int HOLDOFF_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              reset_n,
    ir_cmd_sequencer_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int LW = (LATCH_WIDTH > 1) ? $clog2(LATCH_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_LATCH,
        S_CAPTURE,
        S_FILTER
    } state_t;

    state_t          state_q;
    logic [31:0]     dec_raw_q;
    logic            dec_latch_q;
    logic [LW-1:0]   lat_cnt_q;
    logic            pend_valid_q;
    logic [31:0]     pend_data_q;
    logic [31:0]     cap_code_q;
    logic [31:0]     last_code_q;
    logic [HW-1:0]   holdoff_q;
    logic            drop_unknown_q;
    logic            overflow_q;

    logic [3:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [3:0]      cmd_code_q, cmd_code_d;

    logic            push_req;
    logic            filt_load;
    logic            filt_commit;
    logic            filt_unknown;
    logic            fifo_full;
    logic            pop;
    logic            push_ok;
    logic            frame_drop;
    logic            fifo_drop;

`ifdef IR_AUTO_REPEAT_EN
    localparam int RLOAD = HOLDOFF_CYCLES / 4;
    localparam int RW    = (RLOAD > 0) ? $clog2(RLOAD + 1) : 1;
    logic [RW-1:0]   rep_q;
    logic            rep_load;
    logic            is_dir;
    assign is_dir = (cap_code_q >= 32'd5) && (cap_code_q <= 32'd8);
`endif

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = cmd_valid_q && bus.cmd_ready;
    // A pop in the same cycle frees the head slot, so a push at full is still accepted.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign fifo_drop  = push_req && fifo_full && !pop;
    assign frame_drop = bus.frame_valid && (state_q != S_IDLE) && pend_valid_q;

    // Filter decision for the captured code, only active in FILTER.
    always_comb begin
        push_req     = 1'b0;
        filt_load    = 1'b0;
        filt_commit  = 1'b0;
        filt_unknown = 1'b0;
`ifdef IR_AUTO_REPEAT_EN
        rep_load     = 1'b0;
`endif
        if (state_q == S_FILTER) begin
            if (cap_code_q == 32'd0) begin
                filt_unknown = 1'b1;
            end else if ((cap_code_q == last_code_q) && (holdoff_q != '0)) begin
                filt_load = 1'b1;
`ifdef IR_AUTO_REPEAT_EN
                if (is_dir && (rep_q == '0)) begin
                    push_req = 1'b1;
                    rep_load = 1'b1;
                end
`endif
            end else begin
                push_req    = 1'b1;
                filt_load   = 1'b1;
                filt_commit = 1'b1;
`ifdef IR_AUTO_REPEAT_EN
                rep_load    = 1'b1;
`endif
            end
        end
    end

    // Sequencing FSM: decoder drive/latch/capture, pending slot, filter state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            dec_raw_q      <= '0;
            dec_latch_q    <= 1'b0;
            lat_cnt_q      <= '0;
            pend_valid_q   <= 1'b0;
            pend_data_q    <= '0;
            cap_code_q     <= '0;
            last_code_q    <= '0;
            holdoff_q      <= '0;
            drop_unknown_q <= 1'b0;
        end else begin
            drop_unknown_q <= filt_unknown;
            if (filt_load) begin
                holdoff_q <= HW'(HOLDOFF_CYCLES);
            end else if (holdoff_q != '0) begin
                holdoff_q <= holdoff_q - HW'(1);
            end
            if (filt_commit) begin
                last_code_q <= cap_code_q;
            end

            case (state_q)
                S_IDLE: begin
                    // The pending frame goes first; a same-cycle new frame refills the slot.
                    if (pend_valid_q) begin
                        dec_raw_q <= pend_data_q;
                        state_q   <= S_DRIVE;
                        if (bus.frame_valid) begin
                            pend_data_q <= bus.frame_data;
                        end else begin
                            pend_valid_q <= 1'b0;
                        end
                    end else if (bus.frame_valid) begin
                        dec_raw_q <= bus.frame_data;
                        state_q   <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    dec_latch_q <= 1'b1;
                    lat_cnt_q   <= '0;
                    state_q     <= S_LATCH;
                end
                S_LATCH: begin
                    if (lat_cnt_q == LW'(LATCH_WIDTH - 1)) begin
                        dec_latch_q <= 1'b0;
                        state_q     <= S_CAPTURE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LW'(1);
                    end
                end
                S_CAPTURE: begin
                    cap_code_q <= bus.dec_code;
                    state_q    <= S_FILTER;
                end
                S_FILTER: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    dec_latch_q <= 1'b0;
                end
            endcase

            // Frames arriving mid-sequence park in the single pending slot.
            if ((state_q != S_IDLE) && bus.frame_valid && !pend_valid_q) begin
                pend_valid_q <= 1'b1;
                pend_data_q  <= bus.frame_data;
            end
        end
    end

`ifdef IR_AUTO_REPEAT_EN
    // Auto-repeat rate limiter for held directional codes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_q <= '0;
        end else if (rep_load) begin
            rep_q <= RW'(RLOAD);
        end else if (rep_q != '0) begin
            rep_q <= rep_q - RW'(1);
        end
    end
`endif

    // Sticky overflow from dropped busy frames or pushes into a full FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (frame_drop || fifo_drop) begin
            overflow_q <= 1'b1;
        end
    end

    // FIFO next-state: pointers, occupancy and the registered head word.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (count_d == '0) begin
            cmd_valid_d = 1'b0;
        end else begin
            cmd_valid_d = 1'b1;
            // The new head may be the word being written this very cycle.
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                cmd_code_d = cap_code_q[3:0];
            end else begin
                cmd_code_d = mem_q[rd_ptr_d];
            end
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= cap_code_q[3:0];
        end
    end

    assign bus.dec_raw      = dec_raw_q;
    assign bus.dec_latch    = dec_latch_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_code     = cmd_code_q;
    assign bus.fifo_count   = count_q;
    assign bus.drop_unknown = drop_unknown_q;
    assign bus.overflow     = overflow_q;
    assign bus.busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_ir_cmd_sequencer.sv
// tb_ir_cmd_sequencer: directed self-checking bench for ir_cmd_sequencer with
// a table-driven decoder model (FIFO_DEPTH=4, LATCH_WIDTH=2, HOLDOFF_CYCLES=100).
module tb_ir_cmd_sequencer;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    ir_cmd_sequencer_if #(.FIFO_DEPTH(4)) ifc ();

    ir_cmd_sequencer #(
        .FIFO_DEPTH    (4),
        .LATCH_WIDTH   (2),
        .HOLDOFF_CYCLES(100)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decoder model: fixed frame-to-code table, anything else decodes as unknown.
    always_comb begin
        case (ifc.dec_raw)
            32'h0A04: ifc.dec_code = 32'd5;
            32'h0A0B: ifc.dec_code = 32'd10;
            32'h0A02: ifc.dec_code = 32'd2;
            32'h0A0A: ifc.dec_code = 32'd9;
            32'h0A12: ifc.dec_code = 32'd10;
            32'h0A01: ifc.dec_code = 32'd1;
            32'h0A05: ifc.dec_code = 32'd5;
            32'h0A06: ifc.dec_code = 32'd6;
            32'h0A07: ifc.dec_code = 32'd7;
            default:  ifc.dec_code = 32'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents one frame during the current cycle (cycle 0); returns in cycle 1.
    task automatic send_frame(input logic [31:0] data);
        ifc.frame_data  = data;
        ifc.frame_valid = 1'b1;
        tick();
        ifc.frame_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n         = 1'b0;
        ifc.frame_valid = 1'b0;
        ifc.frame_data  = '0;
        ifc.cmd_ready   = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        ifc.frame_valid = 1'b0;
        ifc.frame_data  = 32'h0A04;
        ifc.cmd_ready   = 1'b0;
        ticks(2);
        total++; if (ifc.dec_raw !== 32'd0) begin bad++; $display("FAIL rst_dec_raw got=%h exp=0", ifc.dec_raw); end
        total++; if (ifc.dec_latch !== 1'b0) begin bad++; $display("FAIL rst_dec_latch got=%b exp=0", ifc.dec_latch); end
        total++; if (ifc.cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid got=%b exp=0", ifc.cmd_valid); end
        total++; if (ifc.cmd_code !== 4'd0) begin bad++; $display("FAIL rst_cmd_code got=%h exp=0", ifc.cmd_code); end
        total++; if (ifc.fifo_count !== 3'd0) begin bad++; $display("FAIL rst_fifo_count got=%0d exp=0", ifc.fifo_count); end
        total++; if (ifc.drop_unknown !== 1'b0) begin bad++; $display("FAIL rst_drop_unknown got=%b exp=0", ifc.drop_unknown); end
        total++; if (ifc.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", ifc.overflow); end
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", ifc.busy); end
        reset_n = 1'b1;
        tick();
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%b exp=0", ifc.busy); end
        $display("test_reset: outputs checked in and after reset");
    endtask

    task automatic test_single_frame();
        int lat_cycles;
        int first_latch;
        int first_valid;
        apply_reset();
        lat_cycles  = 0;
        first_latch = -1;
        first_valid = -1;
        send_frame(32'h0A04);
        total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", ifc.busy); end
        for (int c = 1; c <= 8; c++) begin
            if (ifc.dec_latch === 1'b1) begin
                lat_cycles++;
                if (first_latch < 0) first_latch = c;
            end
            if (ifc.cmd_valid === 1'b1 && first_valid < 0) first_valid = c;
            tick();
        end
        total++; if (lat_cycles != 2) begin bad++; $display("FAIL single_latch_len got=%0d exp=2", lat_cycles); end
        total++; if (first_latch != 2) begin bad++; $display("FAIL single_latch_start got=%0d exp=2", first_latch); end
        total++; if (first_valid != 6) begin bad++; $display("FAIL single_latency got=%0d exp=6", first_valid); end
        total++; if (ifc.dec_raw !== 32'h0A04) begin bad++; $display("FAIL single_dec_raw got=%h exp=00000a04", ifc.dec_raw); end
        total++; if (ifc.cmd_code !== 4'h5) begin bad++; $display("FAIL single_code got=%h exp=5", ifc.cmd_code); end
        total++; if (ifc.fifo_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", ifc.fifo_count); end
        ifc.cmd_ready = 1'b1;
        tick();
        ifc.cmd_ready = 1'b0;
        total++; if (ifc.fifo_count !== 3'd0) begin bad++; $display("FAIL single_pop_count got=%0d exp=0", ifc.fifo_count); end
        total++; if (ifc.cmd_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b exp=0", ifc.cmd_valid); end
        $display("test_single_frame: frame 0x0A04 -> code 5, latency %0d", first_valid);
    endtask

    task automatic test_unknown();
        int drops;
        int valid_seen;
        apply_reset();
        drops      = 0;
        valid_seen = 0;
        send_frame(32'h0AFF);
        for (int c = 1; c <= 9; c++) begin
            if (ifc.drop_unknown === 1'b1) drops++;
            if (ifc.cmd_valid === 1'b1) valid_seen = 1;
            tick();
        end
        total++; if (drops != 1) begin bad++; $display("FAIL unknown_pulses got=%0d exp=1", drops); end
        total++; if (valid_seen != 0) begin bad++; $display("FAIL unknown_cmd_valid got=%0d exp=0", valid_seen); end
        total++; if (ifc.fifo_count !== 3'd0) begin bad++; $display("FAIL unknown_count got=%0d exp=0", ifc.fifo_count); end
        // Code 5, then unknown, then 5 again inside holdoff: last_code must still be 5.
        send_frame(32'h0A04);
        ticks(5);
        total++; if (ifc.fifo_count !== 3'd1) begin bad++; $display("FAIL unknown_first5 got=%0d exp=1", ifc.fifo_count); end
        send_frame(32'h0AFF);
        ticks(5);
        send_frame(32'h0A04);
        ticks(8);
        total++; if (ifc.fifo_count !== 3'd1) begin bad++; $display("FAIL unknown_last_code got=%0d exp=1", ifc.fifo_count); end
        $display("test_unknown: drop pulses=%0d", drops);
    endtask

    task automatic test_repeat();
        apply_reset();
        send_frame(32'h0A0B);    // t=0   pushed
        ticks(49);
        send_frame(32'h0A0B);    // t=50  suppressed, holdoff reloaded
        ticks(89);
        send_frame(32'h0A0B);    // t=140 suppressed, holdoff reloaded
        ticks(10);
        total++; if (ifc.fifo_count !== 3'd1) begin bad++; $display("FAIL repeat_suppressed got=%0d exp=1", ifc.fifo_count); end
        ticks(109);
        send_frame(32'h0A0B);    // t=260 window expired, pushed
        ticks(8);
        total++; if (ifc.fifo_count !== 3'd2) begin bad++; $display("FAIL repeat_total got=%0d exp=2", ifc.fifo_count); end
        total++; if (ifc.cmd_code !== 4'hA) begin bad++; $display("FAIL repeat_code got=%h exp=a", ifc.cmd_code); end
        $display("test_repeat: queued=%0d", ifc.fifo_count);
    endtask

    task automatic test_busy_pending();
        logic [3:0] exp_codes [2];
        exp_codes[0] = 4'd2;
        exp_codes[1] = 4'd9;
        apply_reset();
        ifc.frame_data  = 32'h0A02;
        ifc.frame_valid = 1'b1;
        tick();                       // cycle 1
        ifc.frame_data = 32'h0A0A;
        tick();                       // cycle 2
        ifc.frame_data = 32'h0A12;
        tick();                       // cycle 3
        ifc.frame_valid = 1'b0;
        total++; if (ifc.overflow !== 1'b1) begin bad++; $display("FAIL busy_overflow got=%b exp=1", ifc.overflow); end
        total++; if (ifc.busy !== 1'b1) begin bad++; $display("FAIL busy_flag got=%b exp=1", ifc.busy); end
        ticks(11);                    // cycle 14
        total++; if (ifc.fifo_count !== 3'd2) begin bad++; $display("FAIL busy_count got=%0d exp=2", ifc.fifo_count); end
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b exp=0", ifc.busy); end
        for (int i = 0; i < 2; i++) begin
            total++; if (ifc.cmd_valid !== 1'b1 || ifc.cmd_code !== exp_codes[i]) begin
                bad++; $display("FAIL busy_pop%0d got valid=%b code=%h exp valid=1 code=%h", i, ifc.cmd_valid, ifc.cmd_code, exp_codes[i]);
            end
            ifc.cmd_ready = 1'b1;
            tick();
            ifc.cmd_ready = 1'b0;
        end
        $display("test_busy_pending: queue drained");
    endtask

    task automatic test_fifo_full();
        logic [31:0] frames [5];
        logic [3:0]  drain [4];
        frames[0] = 32'h0A01; frames[1] = 32'h0A02; frames[2] = 32'h0A05;
        frames[3] = 32'h0A06; frames[4] = 32'h0A07;
        drain[0] = 4'd2; drain[1] = 4'd5; drain[2] = 4'd6; drain[3] = 4'd1;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            send_frame(frames[i]);
            ticks(5);
            if (i == 3) begin
                total++; if (ifc.overflow !== 1'b0) begin bad++; $display("FAIL full_early_overflow got=%b exp=0", ifc.overflow); end
            end
        end
        total++; if (ifc.fifo_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", ifc.fifo_count); end
        total++; if (ifc.overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b exp=1", ifc.overflow); end
        total++; if (ifc.cmd_code !== 4'd1) begin bad++; $display("FAIL full_head got=%h exp=1", ifc.cmd_code); end
        // Push (code 1) and pop in the same cycle while full.
        send_frame(32'h0A01);
        ticks(4);                     // FILTER cycle
        ifc.cmd_ready = 1'b1;
        tick();
        ifc.cmd_ready = 1'b0;
        total++; if (ifc.fifo_count !== 3'd4) begin bad++; $display("FAIL full_pushpop_count got=%0d exp=4", ifc.fifo_count); end
        for (int i = 0; i < 4; i++) begin
            total++; if (ifc.cmd_valid !== 1'b1 || ifc.cmd_code !== drain[i]) begin
                bad++; $display("FAIL full_pop%0d got valid=%b code=%h exp valid=1 code=%h", i, ifc.cmd_valid, ifc.cmd_code, drain[i]);
            end
            ifc.cmd_ready = 1'b1;
            tick();
            ifc.cmd_ready = 1'b0;
        end
        total++; if (ifc.fifo_count !== 3'd0) begin bad++; $display("FAIL full_drained got=%0d exp=0", ifc.fifo_count); end
        $display("test_fifo_full: push/pop at full and drain order checked");
    endtask

    task automatic test_reset_mid_latch();
        apply_reset();
        send_frame(32'h0A04);
        tick();                       // cycle 2, inside LATCH
        total++; if (ifc.dec_latch !== 1'b1) begin bad++; $display("FAIL midrst_latch_pre got=%b exp=1", ifc.dec_latch); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (ifc.dec_latch !== 1'b0) begin bad++; $display("FAIL midrst_latch got=%b exp=0", ifc.dec_latch); end
        total++; if (ifc.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", ifc.busy); end
        total++; if (ifc.fifo_count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", ifc.fifo_count); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        send_frame(32'h0A06);
        ticks(5);
        total++; if (ifc.cmd_valid !== 1'b1 || ifc.cmd_code !== 4'd6) begin
            bad++; $display("FAIL midrst_next got valid=%b code=%h exp valid=1 code=6", ifc.cmd_valid, ifc.cmd_code);
        end
        total++; if (ifc.fifo_count !== 3'd1) begin bad++; $display("FAIL midrst_next_count got=%0d exp=1", ifc.fifo_count); end
        $display("test_reset_mid_latch: abort and recovery checked");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_frame();
        test_unknown();
        test_repeat();
        test_busy_pending();
        test_fifo_full();
        test_reset_mid_latch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/ir_cmd_sequencer.md
Name: ir_cmd_sequencer

Overview:
- Sequences the IR code decoder for the game datapath.
- Accepts raw 32-bit IR frames, drives the decoder's raw input and latch strobe, and captures the decoded command.
- Filters out unknown codes and held-button repeats, then buffers accepted commands in a small FIFO.
- Game logic pops commands through a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of 2, minimum 2.
- LATCH_WIDTH, 2: clk cycles dec_latch is held high; minimum 1.
- HOLDOFF_CYCLES, 5000000: repeat-suppression window (100 ms at 50 MHz).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- frame_valid  in  1  single-cycle strobe; frame_data is valid this cycle.
- frame_data  in  32  raw IR frame from the receiver.
- dec_raw  out  32  decoder raw input.
- dec_latch  out  1  decoder latch strobe; registered, glitch-free.
- dec_code  in  32  decoder output; codes 1,2,5..10 are valid, 0 is unknown.
- cmd_valid  out  1  FIFO head is valid.
- cmd_code  out  4  FIFO head command, dec_code[3:0].
- cmd_ready  in  1  consumer accepts the head.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- drop_unknown  out  1  one-cycle pulse when a code of 0 is discarded.
- overflow  out  1  sticky; cleared only by reset.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: dec_raw=0, dec_latch=0, cmd_valid=0, cmd_code=0, fifo_count=0, drop_unknown=0, overflow=0, busy=0. FIFO empties, pending slot clears, holdoff counter=0, last_code=0, FSM goes to IDLE.
- Reset asserted mid-sequence aborts the sequence immediately. dec_latch drops asynchronously.
- FSM states: IDLE, DRIVE, LATCH, CAPTURE, FILTER.
  - IDLE: on frame_valid, or when the pending slot is full, load dec_raw and go to DRIVE. A pending frame has priority over a new frame_valid in the same cycle; the new frame then takes the pending slot.
  - DRIVE: one cycle of dec_raw setup, dec_latch=0, then go to LATCH.
  - LATCH: dec_latch=1 for LATCH_WIDTH cycles. Deassert on the exit edge, then go to CAPTURE.
  - CAPTURE: register dec_code into cap_code, then go to FILTER.
  - FILTER: apply the rules below, then go to IDLE.
- dec_raw holds its value from DRIVE until the next IDLE→DRIVE transition.
- FILTER rules:
  - cap_code==0: pulse drop_unknown. No push; last_code unchanged.
  - cap_code==last_code and holdoff counter nonzero: suppress, and reload the holdoff counter to HOLDOFF_CYCLES.
  - Otherwise: push cap_code[3:0], set last_code=cap_code, load the holdoff counter to HOLDOFF_CYCLES.
- Holdoff counter decrements by 1 per cycle and saturates at 0. Its width is $clog2(HOLDOFF_CYCLES+1).
- Busy frame handling (frame_valid while busy):
  - Pending slot empty: store the frame.
  - Pending slot full: discard the frame and set overflow.
- FIFO push when full: discard the command and set overflow. fifo_count does not change.
- FIFO read side:
  - First-word-fall-through; cmd_code/cmd_valid are driven from the head register.
  - A pop occurs on cmd_valid && cmd_ready.
  - Push and pop in the same cycle: fifo_count is unchanged. This is legal when full, because the pop frees a slot first.
  - Push into an empty FIFO: cmd_valid rises the cycle after FILTER.
- Latency: frame_valid at cycle 0 in IDLE gives cmd_valid at cycle 4+LATCH_WIDTH (cycle 6 with defaults).
- Pointers wrap modulo FIFO_DEPTH. Full = count==FIFO_DEPTH; empty = count==0.
- Back-to-back frames each run the full sequence. Sequence period is 4+LATCH_WIDTH cycles (DRIVE, LATCH, CAPTURE, FILTER, IDLE).

Optional Feature:
- Macro: IR_AUTO_REPEAT_EN.
- When defined:
  - Directional codes 5..8 (UP/DOWN/LEFT/RIGHT) repeated within holdoff are pushed instead of suppressed, but at most one push per HOLDOFF_CYCLES/4 cycles per held code.
  - A second counter is added. Repeats arriving faster than that rate are suppressed.
  - Non-directional codes still follow the normal suppression rule.
- When undefined: all in-window repeats are suppressed; no extra counter exists.

Test Plan:
- Single frame: reset, frame 0x00000A04 with the decoder returning 5 → dec_latch high for exactly 2 cycles, cmd_valid at cycle 6, cmd_code=0x5, fifo_count=1. With cmd_ready=1 → fifo_count=0.
- Unknown code: frame 0x00000AFF with decoder returning 0 → drop_unknown pulses once, cmd_valid stays 0, last_code unchanged.
- Repeat suppression (HOLDOFF_CYCLES=100): frames 0x0A0B at t=0, 50, 140 → only the first is pushed. At t=260 (>100 after the t=140 reload) the frame is pushed again → 2 commands total.
- Busy and pending: frame 0x0A02, then frames 0x0A0A and 0x0A12 at cycles +1 and +2 → 0x0A0A is pending and processed, 0x0A12 is dropped, overflow=1. Queue holds 2, 9.
- FIFO full (FIFO_DEPTH=4, cmd_ready=0): distinct codes 1,2,5,6,7 → fifo_count=4, overflow=1, pop order 1,2,5,6. A push and pop in the same cycle at full keeps fifo_count=4.
- Reset mid-LATCH: assert reset_n=0 while dec_latch=1 → dec_latch=0 and busy=0 immediately, FIFO empty. The next frame after release processes normally.
